// File: rtl/rsa4k_job_arbiter_if.sv
// Requester-side bundle of the rsa4k job arbiter: level requests,
// per-requester operands, one-hot grant and the valid/ready response.
interface rsa4k_job_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4096
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] msg_in;
  logic [NUM_REQ*WIDTH-1:0] exp_in;
  logic [NUM_REQ*WIDTH-1:0] mod_in;
  logic [NUM_REQ-1:0]       gnt;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IW-1:0]            rsp_id;
  logic [WIDTH-1:0]         rsp_cypher;
  logic                     rsp_err;

  modport master (
    output req, msg_in, exp_in, mod_in, rsp_ready,
    input  gnt, rsp_valid, rsp_id, rsp_cypher, rsp_err
  );

  modport slave (
    input  req, msg_in, exp_in, mod_in, rsp_ready,
    output gnt, rsp_valid, rsp_id, rsp_cypher, rsp_err
  );
endinterface

// File: rtl/rsa4k_job_arbiter.sv
// Round-robin scheduler sharing one rsa4k modexp core among NUM_REQ users.
// Optional watchdog abort is enabled by defining RSA_ARB_TIMEOUT_EN.
module rsa4k_job_arbiter #(
  parameter int          NUM_REQ        = 4,
  parameter int          WIDTH          = 4096,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_000_000
) (
  input  logic              clk,
  input  logic              reset,
  rsa4k_job_arbiter_if.slave job,
  output logic              core_go_o,
  output logic              core_reset_o,
  output logic [WIDTH-1:0]  core_msg_o,
  output logic [WIDTH-1:0]  core_exp_o,
  output logic [WIDTH-1:0]  core_mod_o,
  input  logic              core_done_i,
  input  logic [WIDTH-1:0]  core_cypher_i,
  output logic              busy_o
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] BUSY  = 3'd3;
  localparam logic [2:0] RESP  = 3'd5;
`ifdef RSA_ARB_TIMEOUT_EN
  localparam logic [2:0] ABORT = 3'd4;
`endif

  logic [2:0]         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               go_q, go_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]      rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   cyph_q, cyph_d;
  logic [WIDTH-1:0]   msg_q, msg_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic [WIDTH-1:0]   mod_q, mod_d;
  logic               done_q, done_d;
  logic               first_q, first_d;
`ifdef RSA_ARB_TIMEOUT_EN
  logic [31:0]        cnt_q, cnt_d;
  logic               ab_q, ab_d;
  logic               err_q, err_d;
`endif

  logic [IW-1:0]      pick;
  logic               any_req;
  logic [IW:0]        cand;
  logic [IW:0]        inc;
  logic [IW-1:0]      rr_nxt;
  logic [WIDTH-1:0]   sel_msg;
  logic [WIDTH-1:0]   sel_exp;
  logic [WIDTH-1:0]   sel_mod;

  // first set request at or after rr_q, wrapping; lowest offset wins
  always_comb begin
    pick    = rr_q;
    any_req = 1'b0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_q} + (IW+1)'(k);
      if (cand >= NR) cand = cand - NR;
      if (job.req[cand[IW-1:0]]) begin
        pick    = cand[IW-1:0];
        any_req = 1'b1;
      end
    end
  end

  assign inc    = {1'b0, owner_q} + (IW+1)'(1);
  assign rr_nxt = (inc >= NR) ? '0 : inc[IW-1:0];

  // operand slices of the current owner
  always_comb begin
    sel_msg = '0;
    sel_exp = '0;
    sel_mod = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IW'(i)) begin
        sel_msg = job.msg_in[i*WIDTH +: WIDTH];
        sel_exp = job.exp_in[i*WIDTH +: WIDTH];
        sel_mod = job.mod_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // job sequencing: arbitrate, load, kick the core, wait, respond
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    gnt_d       = '0;
    go_d        = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    cyph_d      = cyph_q;
    msg_d       = msg_q;
    exp_d       = exp_q;
    mod_d       = mod_q;
    done_d      = done_q;
    first_d     = first_q;
`ifdef RSA_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    ab_d        = ab_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = LOAD;
          owner_d = pick;
          gnt_d   = NUM_REQ'(1) << pick;
        end
      end
      LOAD: begin
        msg_d   = sel_msg;
        exp_d   = sel_exp;
        mod_d   = sel_mod;
        rr_d    = rr_nxt;
        go_d    = 1'b1;
        state_d = START;
      end
      START: begin
        done_d  = 1'b0;
        first_d = 1'b1;
`ifdef RSA_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = BUSY;
      end
      BUSY: begin
        done_d  = core_done_i;
        first_d = 1'b0;
`ifdef RSA_ARB_TIMEOUT_EN
        cnt_d   = cnt_q + 32'd1;
`endif
        // the core may still show last job's done in the first cycle
        if (~first_q & core_done_i & ~done_q) begin
          cyph_d      = core_cypher_i;
          rsp_valid_d = 1'b1;
          rsp_id_d    = owner_q;
          state_d     = RESP;
`ifdef RSA_ARB_TIMEOUT_EN
          err_d       = 1'b0;
        end else if (cnt_q + 32'd1 >= TIMEOUT_CYCLES) begin
          ab_d    = 1'b0;
          state_d = ABORT;
`endif
        end
      end
`ifdef RSA_ARB_TIMEOUT_EN
      ABORT: begin
        ab_d = 1'b1;
        if (ab_q) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = owner_q;
          cyph_d      = '0;
          err_d       = 1'b1;
          state_d     = RESP;
        end
      end
`endif
      RESP: begin
        if (job.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
`ifdef RSA_ARB_TIMEOUT_EN
          err_d       = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_q        <= '0;
      gnt_q       <= '0;
      go_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      cyph_q      <= '0;
      msg_q       <= '0;
      exp_q       <= '0;
      mod_q       <= '0;
      done_q      <= 1'b0;
      first_q     <= 1'b0;
`ifdef RSA_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      ab_q        <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      go_q        <= go_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      cyph_q      <= cyph_d;
      msg_q       <= msg_d;
      exp_q       <= exp_d;
      mod_q       <= mod_d;
      done_q      <= done_d;
      first_q     <= first_d;
`ifdef RSA_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      ab_q        <= ab_d;
      err_q       <= err_d;
`endif
    end
  end

  assign job.gnt        = gnt_q;
  assign job.rsp_valid  = rsp_valid_q;
  assign job.rsp_id     = rsp_id_q;
  assign job.rsp_cypher = cyph_q;
  assign core_go_o      = go_q;
  assign core_msg_o     = msg_q;
  assign core_exp_o     = exp_q;
  assign core_mod_o     = mod_q;
  assign busy_o         = (state_q != IDLE);
`ifdef RSA_ARB_TIMEOUT_EN
  assign job.rsp_err    = err_q;
  assign core_reset_o   = reset | (state_q == ABORT);
`else
  assign job.rsp_err    = 1'b0;
  assign core_reset_o   = reset;
`endif
endmodule

// File: tb/tb_rsa4k_job_arbiter.sv
// Scoreboard bench for rsa4k_job_arbiter with a behavioural core stub.
// Watchdog scenario runs only when RSA_ARB_TIMEOUT_EN is defined.
module tb_rsa4k_job_arbiter;
  localparam int NR  = 4;
  localparam int W   = 16;
  localparam int TMO = 1000;

  typedef struct {
    int         id;
    logic [W-1:0] cy;
    logic       err;
  } rsp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         core_go, core_reset, core_done, busy;
  logic [W-1:0] core_msg, core_exp, core_mod, core_cy;

  rsa4k_job_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) job_if ();

  rsa4k_job_arbiter #(
    .NUM_REQ(NR), .WIDTH(W), .TIMEOUT_CYCLES(32'(TMO))
  ) dut (
    .clk(clk), .reset(reset), .job(job_if.slave),
    .core_go_o(core_go), .core_reset_o(core_reset),
    .core_msg_o(core_msg), .core_exp_o(core_exp),
    .core_mod_o(core_mod), .core_done_i(core_done),
    .core_cypher_i(core_cy), .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] modexp(
    input logic [W-1:0] m, input logic [W-1:0] e,
    input logic [W-1:0] n);
    logic [31:0] r, b, nn;
    nn = 32'(n);
    r  = 32'd1;
    b  = 32'(m) % nn;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[W-1:0];
  endfunction

  // core stub: fixed latency, done stays high until the next go
  int st_lat  = 20;
  int hang_at = 0;
  int go_cnt  = 0;
  int st_cnt  = 0;
  always @(posedge clk) begin
    if (core_reset) begin
      core_done <= 1'b0;
      st_cnt    <= 0;
    end else if (core_go) begin
      core_done <= 1'b0;
      go_cnt    <= go_cnt + 1;
      st_cnt    <= (go_cnt + 1 == hang_at) ? 0 : st_lat;
      core_cy   <= modexp(core_msg, core_exp, core_mod);
    end else if (st_cnt > 0) begin
      st_cnt <= st_cnt - 1;
      if (st_cnt == 1) core_done <= 1'b1;
    end
  end

  int n_chk = 0, n_fail = 0, n_rsp = 0, cyc = 0;
  int gnt_cyc = 0, go_cyc = 0, done_cyc = 0, val_cyc = 0;
  int hs_cyc = 0, rp_len = 0;
  int left [NR];
  logic [NR-1:0] prev_gnt = '0;
  logic prev_done = 1'b0, prev_valid = 1'b0;
  logic [W-1:0] m_op [NR], e_op [NR], n_op [NR];
  int gq [$];
  rsp_t rq [$];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ex(input int i);
    return modexp(m_op[i], e_op[i], n_op[i]);
  endfunction

  task automatic exp_job(input int id, input logic [W-1:0] cy,
                         input logic err);
    rsp_t r;
    r.id = id; r.cy = cy; r.err = err;
    gq.push_back(id);
    rq.push_back(r);
  endtask

  // one clock: handshake is judged on the values set up for the coming edge
  task automatic tick();
    logic hs;
    logic [1:0] id_s;
    logic [W-1:0] cy_s;
    logic er_s;
    int c_before;
    hs = job_if.rsp_valid === 1'b1 && job_if.rsp_ready === 1'b1;
    id_s = job_if.rsp_id;
    cy_s = job_if.rsp_cypher;
    er_s = job_if.rsp_err;
    c_before = cyc;
    @(negedge clk);
    cyc++;
    if (hs) begin
      if (rq.size() == 0) check("rsp_unexp", 64'(hs), 64'(0));
      else begin
        rsp_t r;
        r = rq.pop_front();
        check("rsp_id", 64'(id_s), 64'(r.id));
        check("rsp_cypher", 64'(cy_s), 64'(r.cy));
        check("rsp_err", 64'(er_s), 64'(r.err));
      end
      n_rsp++;
      hs_cyc = c_before;
    end
    if (job_if.gnt !== '0) begin
      check("gnt_1cyc", 64'(prev_gnt), 64'(0));
      if (gq.size() == 0) check("gnt_unexp", 64'(job_if.gnt), 64'(0));
      else begin
        int e;
        e = gq.pop_front();
        check("gnt", 64'(job_if.gnt), 64'(1) << e);
      end
      gnt_cyc = cyc;
      for (int i = 0; i < NR; i++) begin
        if (job_if.gnt[i]) begin
          if (left[i] > 0) left[i]--;
          if (left[i] == 0) job_if.req[i] = 1'b0;
        end
      end
    end
    prev_gnt = job_if.gnt;
    if (core_go === 1'b1) go_cyc = cyc;
    if (core_done === 1'b1 && !prev_done) done_cyc = cyc;
    prev_done = (core_done === 1'b1);
    if (job_if.rsp_valid === 1'b1 && !prev_valid) val_cyc = cyc;
    prev_valid = (job_if.rsp_valid === 1'b1);
    if (core_reset === 1'b1 && !reset) rp_len++;
  endtask

  task automatic wait_rsp(input int k, input int bud);
    int tgt = n_rsp + k;
    int n = 0;
    while (n_rsp < tgt && n < bud) begin
      tick();
      n++;
    end
    check("rsp_wait", 64'(n_rsp), 64'(tgt));
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_gnt"}, 64'(job_if.gnt), 64'(0));
    check({tag, "_valid"}, 64'(job_if.rsp_valid), 64'(0));
    check({tag, "_err"}, 64'(job_if.rsp_err), 64'(0));
    check({tag, "_go"}, 64'(core_go), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_id"}, 64'(job_if.rsp_id), 64'(0));
    check({tag, "_cy"}, 64'(job_if.rsp_cypher), 64'(0));
    check({tag, "_msg"}, 64'(core_msg), 64'(0));
    check({tag, "_exp"}, 64'(core_exp), 64'(0));
    check({tag, "_mod"}, 64'(core_mod), 64'(0));
    check({tag, "_core_rst"}, 64'(core_reset), 64'(1));
  endtask

  initial begin
    int c0, h, n;
    m_op[0] = 16'd4;     e_op[0] = 16'd13;  n_op[0] = 16'd497;
    m_op[1] = 16'd7;     e_op[1] = 16'd11;  n_op[1] = 16'd1009;
    m_op[2] = 16'd3;     e_op[2] = 16'd200; n_op[2] = 16'd65521;
    m_op[3] = 16'd12345; e_op[3] = 16'd77;  n_op[3] = 16'd40009;
    for (int i = 0; i < NR; i++) begin
      left[i] = 0;
      job_if.msg_in[i*W +: W] = m_op[i];
      job_if.exp_in[i*W +: W] = e_op[i];
      job_if.mod_in[i*W +: W] = n_op[i];
    end
    job_if.req = '0;
    job_if.rsp_ready = 1'b1;
    reset = 1'b1;

    repeat (3) tick();
    chk_zero("rst");

    // single job, latency of grant / go / response
    reset = 1'b0;
    job_if.req = 4'b0001;
    left[0] = 1;
    c0 = cyc;
    exp_job(0, W'(445), 1'b0);
    wait_rsp(1, 300);
    check("s1_gnt_lat", 64'(gnt_cyc - c0), 64'(1));
    check("s1_go_lat", 64'(go_cyc - c0), 64'(2));
    check("s1_rsp_lat", 64'(val_cyc - done_cyc), 64'(1));
    check("s1_core_msg", 64'(core_msg), 64'(4));
    check("s1_core_mod", 64'(core_mod), 64'(497));

    // simultaneous requests from reset, slow core
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    st_lat = 100;
    job_if.req = 4'b1010;
    left[1] = 1;
    left[3] = 1;
    exp_job(1, ex(1), 1'b0);
    exp_job(3, ex(3), 1'b0);
    wait_rsp(2, 600);

    // fairness: all four hold req for two jobs each
    st_lat = 5;
    for (int i = 0; i < NR; i++) left[i] = 2;
    job_if.req = 4'b1111;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) exp_job(i, ex(i), 1'b0);
    wait_rsp(8, 800);

    // backpressure
    job_if.rsp_ready = 1'b0;
    left[1] = 1;
    left[2] = 1;
    job_if.req = 4'b0110;
    exp_job(1, ex(1), 1'b0);
    exp_job(2, ex(2), 1'b0);
    n = 0;
    while (job_if.rsp_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("bp_valid", 64'(job_if.rsp_valid), 64'(1));
    repeat (50) begin
      tick();
      check("bp_hold_v", 64'(job_if.rsp_valid), 64'(1));
      check("bp_hold_id", 64'(job_if.rsp_id), 64'(1));
      check("bp_hold_cy", 64'(job_if.rsp_cypher), 64'(ex(1)));
      check("bp_no_gnt", 64'(job_if.gnt), 64'(0));
    end
    job_if.rsp_ready = 1'b1;
    tick();
    h = hs_cyc;
    check("bp_idle", 64'(busy), 64'(0));
    wait_rsp(1, 300);
    check("bp_regnt", 64'(gnt_cyc - h), 64'(2));

`ifdef RSA_ARB_TIMEOUT_EN
    // watchdog: first job hangs, the queued one completes
    rp_len = 0;
    st_lat = 5;
    hang_at = go_cnt + 1;
    left[0] = 1;
    left[1] = 1;
    job_if.req = 4'b0011;
    exp_job(0, '0, 1'b1);
    exp_job(1, ex(1), 1'b0);
    wait_rsp(2, 3000);
    check("wd_rst_len", 64'(rp_len), 64'(2));
`endif

    // reset in the middle of a job drops it
    st_lat = 200;
    left[0] = 1;
    job_if.req = 4'b0001;
    gq.push_back(0);
    repeat (10) tick();
    check("mid_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    job_if.req = '0;
    left[0] = 0;
    tick();
    chk_zero("mid_rst");
    tick();
    check("mid_core_rst", 64'(core_reset), 64'(1));
    reset = 1'b0;
    st_lat = 10;
    left[2] = 1;
    job_if.req = 4'b0100;
    c0 = cyc;
    exp_job(2, ex(2), 1'b0);
    wait_rsp(1, 300);
    check("post_rst_gnt", 64'(gnt_cyc - c0), 64'(1));
    repeat (5) tick();

    check("gq_empty", 64'(gq.size()), 64'(0));
    check("rq_empty", 64'(rq.size()), 64'(0));
`ifndef RSA_ARB_TIMEOUT_EN
    check("no_core_rst", 64'(rp_len), 64'(0));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
